uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Round-robin scheduler sharing the single UART transmitter among N_REQ byte-stream requesters, e.g. the board dumper, status reporter and echo path.
- Each requester sends packets: byte streams with a valid/ready handshake and a last flag.
- A granted requester keeps the transmitter until its last byte is sent, so packets never interleave on the serial line.
- Sits between the requesters and the UART tx_data/tx_start/tx_busy ports.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- IDLE_TIMEOUT, 1_000_000, clock cycles a locked requester may leave valid low mid-packet before it is forcibly released.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- req_valid  in  N_REQ  per-requester byte valid
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  N_REQ  byte is final byte of its packet
- req_ready  out  N_REQ  one-cycle pulse: byte of requester i accepted this cycle
- grant  out  N_REQ  one-hot; requester currently owning the transmitter
- uart_tx_data  out  8  byte to the UART
- uart_tx_start  out  1  start request to the UART
- uart_tx_busy  in  1  UART busy, registered in the UART (rises one cycle after an accepted start)
- timeout_err  out  1  one-cycle pulse when a packet lock is dropped by timeout

Behaviour:
- Reset values (asynchronous, all registers):
  - state=IDLE, grant=0, req_ready=0, uart_tx_start=0, uart_tx_data=0, timeout_err=0
  - rr_ptr=0, timer=0, last_flag=0
- States: IDLE, FETCH, START, WAIT_HI, WAIT_LO.
- IDLE:
  - Scan req_valid starting at rr_ptr, wrapping modulo N_REQ; the first set bit wins.
  - On a winner k, in the same cycle:
    - latch req_data[k] into uart_tx_data and req_last[k] into last_flag;
    - pulse req_ready[k]; set grant to one-hot k; go to START.
  - With no valid request, stay in IDLE with grant=0.
- FETCH (granted requester k, mid-packet):
  - If req_valid[k]: latch data and last, pulse req_ready[k], clear timer, go to START.
  - Otherwise increment timer. When timer reaches IDLE_TIMEOUT-1:
    - pulse timeout_err, clear grant, set rr_ptr=(k+1) mod N_REQ, go to IDLE.
- START:
  - Hold uart_tx_start=1 and uart_tx_data stable.
  - When uart_tx_busy=1, drop uart_tx_start to 0 in that same cycle (combinational on the state and busy, or registered so start is never high when busy falls) and go to WAIT_LO.
  - WAIT_HI is an alias of START. It exists only to bound the wait: if busy has not risen after 4 cycles, stay asserting. This is not an error.
- WAIT_LO:
  - Wait for uart_tx_busy=0.
  - If last_flag=1: clear grant, set rr_ptr=(k+1) mod N_REQ, go to IDLE.
  - Else go to FETCH with timer=0.
- Hard rule: uart_tx_start is never 1 in the cycle busy falls. This prevents a double send of the stale byte.
- req_ready:
  - At most one bit set per cycle, and only for the granted or winning requester.
  - Exactly one pulse per byte.
- Fairness: after a packet ends or times out, the finished requester has the lowest priority.
- Latency from IDLE with req_valid to uart_tx_start=1: 1 cycle.
- Inter-byte overhead: 3 cycles beyond the UART frame.
- A single-byte packet (last=1 on the first byte) releases immediately after its frame.
- Simultaneous requests in IDLE: resolved by rr_ptr only. req_last on a non-granted requester is ignored.
- Reset mid-frame: the controller returns to IDLE. The UART is reset by the same signal, so no partial handshake survives. Requesters must treat an un-acked byte as not sent.

Decomposition:
- Shared package holds the state encoding constants (IDLE..WAIT_LO) and the default IDLE_TIMEOUT.
- One natural sub-module: rr_arbiter. It is combinational: inputs req[N_REQ] and rr_ptr, outputs one-hot winner and any_valid. It is reusable for other shared resources such as the RX dispatcher.

Test Plan:
All scenarios use a UART model with busy asserted for 20 cycles starting one cycle after start, and IDLE_TIMEOUT set to 50.
1. Requester 0 sends a 3-byte packet 0x53,0x55,0x44 (last on 0x44) -> exactly three start pulses in order, three req_ready[0] pulses, grant=001 throughout, grant=000 after the final busy fall.
2. Requesters 0 and 2 both valid at reset release with 1-byte packets, then repeated continuously -> service order 0,2,0,2,... and no requester served twice in a row while the other waits.
3. Requester 1 holds a 2-byte packet while requester 0 requests mid-packet -> requester 0's byte is not emitted until after requester 1's last byte; no interleaving on uart_tx_data.
4. Requester 0 sends a first byte without last, then keeps valid low for 50 cycles -> timeout_err pulses once, grant clears, and a pending requester 1 is granted on the next IDLE cycle.
5. UART model holds busy high for an extra 100 cycles -> uart_tx_start stays 0 throughout, with exactly one start per byte.
6. Reset asserted during WAIT_LO of a 2-byte packet -> all outputs at reset values within the same cycle; after release with requester 0 still valid, a fresh transfer starts cleanly at rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and timing defaults.
package uart_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } sched_state_t;

    localparam int DEFAULT_IDLE_TIMEOUT = 1_000_000;

    // Cycles spent in START before the wait is relabelled WAIT_HI; start stays asserted either way.
    localparam int START_WAIT_CYCLES = 4;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after rr_ptr (wrapping) wins.
module uart_tx_scheduler_rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] winner,
    output logic             any_valid
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int o = 0; o < N_REQ; o++) begin
            idx = PTR_W'((int'(rr_ptr) + o) % N_REQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin owner of the single UART transmitter; a granted requester keeps it until its last byte.
// Requester handshake: requester i holds req_valid/req_data/req_last until req_ready[i] pulses for one cycle.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         uart_tx_data,
    output logic               uart_tx_start,
    input  logic               uart_tx_busy,
    output logic               timeout_err
);

    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TIMER_W = $clog2(IDLE_TIMEOUT + 1);

    sched_state_t       state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         start_wait;
    logic               last_flag;

    logic [N_REQ-1:0]   winner;
    logic               any_valid;
    logic [PTR_W-1:0]   win_idx;
    logic [7:0]         win_data;
    logic               win_last;
    logic               cur_valid;
    logic [7:0]         cur_data;
    logic               cur_last;

    uart_tx_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_comb begin
        win_idx   = '0;
        win_data  = '0;
        win_last  = 1'b0;
        cur_valid = 1'b0;
        cur_data  = '0;
        cur_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner[i]) begin
                win_idx  = PTR_W'(i);
                win_data = req_data[8*i +: 8];
                win_last = req_last[i];
            end
            if (grant_idx == PTR_W'(i)) begin
                cur_valid = req_valid[i];
                cur_data  = req_data[8*i +: 8];
                cur_last  = req_last[i];
            end
        end
    end

    // The finished owner drops to lowest priority on release.
    assign next_ptr = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

    // Start is gated by busy so it falls in the very cycle the UART takes the byte and can never
    // be high when busy falls, which would resend the stale byte.
    assign uart_tx_start = ((state == ST_START) || (state == ST_WAIT_HI)) && !uart_tx_busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            grant        <= '0;
            grant_idx    <= '0;
            req_ready    <= '0;
            uart_tx_data <= '0;
            timeout_err  <= 1'b0;
            rr_ptr       <= '0;
            timer        <= '0;
            start_wait   <= '0;
            last_flag    <= 1'b0;
        end else begin
            req_ready   <= '0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        uart_tx_data <= win_data;
                        last_flag    <= win_last;
                        req_ready    <= winner;
                        grant        <= winner;
                        grant_idx    <= win_idx;
                        start_wait   <= '0;
                        state        <= ST_START;
                    end else begin
                        grant <= '0;
                    end
                end
                ST_FETCH: begin
                    if (cur_valid) begin
                        uart_tx_data <= cur_data;
                        last_flag    <= cur_last;
                        req_ready    <= grant;
                        timer        <= '0;
                        start_wait   <= '0;
                        state        <= ST_START;
                    end else if (timer == TIMER_W'(IDLE_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        grant       <= '0;
                        rr_ptr      <= next_ptr;
                        timer       <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_START, ST_WAIT_HI: begin
                    if (uart_tx_busy) begin
                        state <= ST_WAIT_LO;
                    end else if (state == ST_START) begin
                        if (start_wait == 3'(START_WAIT_CYCLES - 1)) begin
                            state <= ST_WAIT_HI;
                        end else begin
                            start_wait <= start_wait + 3'd1;
                        end
                    end
                end
                ST_WAIT_LO: begin
                    if (!uart_tx_busy) begin
                        if (last_flag) begin
                            grant  <= '0;
                            rr_ptr <= next_ptr;
                            state  <= ST_IDLE;
                        end else begin
                            timer <= '0;
                            state <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
